// File: rtl/approx_add_pipe.sv
// Two-stage pipelined approximate adder: the low p bits are OR-ed, and the
// upper bits are added exactly with a carry guessed from bit p-1.
// Ports: clk/rst_n; in_valid/in_ready with a, b and level (p, clamped to MAXP);
// out_valid/out_ready with y (approx sum) and err (|exact - y|);
// clear_stats zeroes err_cnt (saturating count of beats with err != 0)
// and max_err (largest err delivered).
module approx_add_pipe #(
   parameter int WIDTH = 8,
   parameter int MAXP  = 4,
   parameter int LW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [LW-1:0]    level,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   y,
   output logic [WIDTH:0]   err,
   input  logic             clear_stats,
   output logic [15:0]      err_cnt,
   output logic [WIDTH:0]   max_err
);

   localparam int W1 = WIDTH + 1;
   localparam logic [LW-1:0] PMAX = LW'(MAXP);

   logic             s1_valid_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [LW-1:0]    p_q;
   logic [LW-1:0]    p_d;
   logic             out_valid_q;
   logic [W1-1:0]    y_q;
   logic [W1-1:0]    y_d;
   logic [W1-1:0]    err_q;
   logic [W1-1:0]    err_d;
   logic [15:0]      cnt_q;
   logic [15:0]      cnt_d;
   logic [W1-1:0]    max_q;
   logic [W1-1:0]    max_d;

   logic s2_adv;
   logic s1_adv;
   logic accept;
   logic out_fire;

   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = s2_adv || !s1_valid_q;
   // Held low during reset so nothing is accepted before release.
   assign in_ready = rst_n && s1_adv;
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   assign p_d = (level > PMAX) ? PMAX : level;

   logic [W1-1:0] ax;
   logic [W1-1:0] bx;
   logic [W1-1:0] mask;
   logic [W1-1:0] cin;
   logic [W1-1:0] lo;
   logic [W1-1:0] hi;
   logic [W1-1:0] exact;

   always_comb begin
      ax    = {1'b0, a_q};
      bx    = {1'b0, b_q};
      mask  = (W1'(1) << p_q) - W1'(1);
      // Bit p-1 of a&b moved up to bit p; p=0 yields no carry.
      cin   = ((ax & bx) << 1) & (W1'(1) << p_q);
      lo    = (ax | bx) & mask;
      hi    = (ax & ~mask) + (bx & ~mask) + cin;
      y_d   = hi | lo;
      exact = ax + bx;
      err_d = (exact >= y_d) ? exact - y_d : y_d - exact;
   end

   always_comb begin
      cnt_d = cnt_q;
      max_d = max_q;
      if (clear_stats) begin
         cnt_d = '0;
         max_d = '0;
      end else if (out_fire) begin
         if (err_q != '0 && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
         if (err_q > max_q)
            max_d = err_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         p_q        <= '0;
      end else if (s1_adv) begin
         s1_valid_q <= accept;
         if (accept) begin
            a_q <= a;
            b_q <= b;
            p_q <= p_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         err_q       <= '0;
      end else if (s2_adv) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            y_q   <= y_d;
            err_q <= err_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         max_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         max_q <= max_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign err       = err_q;
   assign err_cnt   = cnt_q;
   assign max_err   = max_q;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: directed cases, backpressure, stats saturation,
// reset flush and a randomized stream against an arithmetic reference.
module tb_approx_add_pipe;

   localparam int WIDTH = 8;
   localparam int MAXP  = 4;
   localparam int LW    = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [LW-1:0]    level;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   y;
   logic [WIDTH:0]   err;
   logic             clear_stats;
   logic [15:0]      err_cnt;
   logic [WIDTH:0]   max_err;

   approx_add_pipe #(.WIDTH(WIDTH), .MAXP(MAXP), .LW(LW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .level      (level),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .y          (y),
      .err        (err),
      .clear_stats(clear_stats),
      .err_cnt    (err_cnt),
      .max_err    (max_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int av;
      int bv;
      int lv;
   } beat_t;

   beat_t q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    m_cnt = 0;
   int    m_max = 0;
   int    n_out = 0;
   int    acc_cnt = 0;
   bit    hold_pend = 0;
   int    hy;
   int    he;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic int ref_y(input int av, input int bv, input int lv);
      int p;
      int pw;
      int c;
      int lo;
      p  = (lv > MAXP) ? MAXP : lv;
      pw = 2 ** p;
      c  = 0;
      lo = 0;
      if (p > 0)
         c = ((av / (pw / 2)) % 2) * ((bv / (pw / 2)) % 2);
      for (int i = 0; i < p; i++)
         if (((av >> i) & 1) == 1 || ((bv >> i) & 1) == 1)
            lo += 2 ** i;
      return (av / pw + bv / pw + c) * pw + lo;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         int  ry;
         int  re;
         bit  fire;
         beat_t bt;
         fire = 0;
         re   = 0;
         chk("err_cnt", err_cnt, m_cnt);
         chk("max_err", max_err, m_max);
         if (hold_pend) begin
            chk("hold_vld", out_valid, 1);
            chk("hold_y", y, hy);
            chk("hold_err", err, he);
         end
         if (out_valid && out_ready) begin
            hold_pend = 0;
            if (q.size() == 0) begin
               chk("orphan", q.size(), 1);
            end else begin
               bt = q.pop_front();
               ry = ref_y(bt.av, bt.bv, bt.lv);
               re = (bt.av + bt.bv) - ry;
               if (re < 0) re = -re;
               chk("y", y, ry);
               chk("err", err, re);
               fire = 1;
               n_out++;
            end
         end else if (out_valid) begin
            hold_pend = 1;
            hy = y;
            he = err;
         end
         if (clear_stats) begin
            m_cnt = 0;
            m_max = 0;
         end else if (fire) begin
            if (re != 0 && m_cnt < 65535) m_cnt++;
            if (re > m_max) m_max = re;
         end
         if (in_valid && in_ready)
            q.push_back('{int'(a), int'(b), int'(level)});
      end
   end

   task automatic push(input int av, input int bv, input int lv);
      int   n;
      logic ok;
      n = 0;
      ok = 0;
      in_valid = 1;
      a = WIDTH'(av);
      b = WIDTH'(bv);
      level = LW'(lv);
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 50);
      if (!ok) chk("push_timeout", ok, 1);
      acc_cnt++;
      in_valid = 0;
   endtask

   task automatic one(input int av, input int bv, input int lv,
                      input int ey, input int ee);
      int k;
      k = 0;
      out_ready = 1;
      push(av, bv, lv);
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 10);
      chk("latency", k, 2);
      chk("y_dir", y, ey);
      chk("err_dir", err, ee);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int base;
      rst_n = 0;
      in_valid = 0;
      a = '0;
      b = '0;
      level = '0;
      out_ready = 1;
      clear_stats = 0;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_max_err", max_err, 0);
      @(posedge clk);
      #3 rst_n = 1;
      #1 chk("rel_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      one('h0F, 'h01, 3, 'h00F, 1);
      chk("cnt_a", err_cnt, 1);
      one('hFF, 'h01, 0, 'h100, 0);
      chk("cnt_b", err_cnt, 1);
      one('h03, 'h03, 2, 'h007, 1);
      chk("cnt_c", err_cnt, 2);
      clear_stats = 1;
      @(posedge clk);
      #1 clear_stats = 0;
      chk("cnt_clr", err_cnt, 0);
      one('h0F, 'h0F, 7, 'h01F, 1);
      one('h0F, 'h0F, 4, 'h01F, 1);
      chk("max_clamp", max_err, 1);
      chk("cnt_clamp", err_cnt, 2);
      one('h08, 'h08, 4, 'h018, 8);
      chk("max_big", max_err, 8);

      base = n_out;
      acc_cnt = 0;
      out_ready = 0;
      fork
         begin
            for (int i = 0; i < 4; i++)
               push(16 * i + 5, 3 * i + 7, i + 1);
         end
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("bp_acc", acc_cnt, 2);
            chk("bp_ready", in_ready, 0);
            @(posedge clk);
            #1 out_ready = 1;
         end
      join
      repeat (6) @(posedge clk);
      #1 chk("bp_delivered", n_out - base, 4);

      a = 8'h0F;
      b = 8'h0F;
      level = 3'd4;
      in_valid = 1;
      repeat (65540) @(posedge clk);
      #1 in_valid = 0;
      repeat (4) @(posedge clk);
      #1 chk("sat_cnt", err_cnt, 'hFFFF);

      push('h0F, 'h0F, 4);
      @(posedge clk);
      #1 chk("clr_beat_vld", out_valid, 1);
      clear_stats = 1;
      @(posedge clk);
      #1 clear_stats = 0;
      chk("clr_cnt", err_cnt, 0);
      chk("clr_max", max_err, 0);

      push(1, 2, 1);
      push(3, 4, 2);
      #2 rst_n = 0;
      q.delete();
      m_cnt = 0;
      m_max = 0;
      hold_pend = 0;
      #1;
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_in_ready", in_ready, 0);
      chk("rst2_y", y, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("ghost", seen, 0);
      @(posedge clk);
      #1 one('h22, 'h11, 0, 'h033, 0);

      for (int i = 0; i < 3000; i++) begin
         in_valid = ($urandom % 4) != 0;
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         level = LW'($urandom % 8);
         out_ready = ($urandom % 4) != 0;
         clear_stats = ($urandom % 50) == 0;
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      out_ready = 1;
      clear_stats = 0;
      repeat (6) @(posedge clk);
      #1 chk("drain", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/approx_add_pipe.md
APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (>=2).
REQ-002 Parameter MAXP, default 4, maximum number of approximated low bits (0..WIDTH-1).
REQ-003 Parameter LW, default 3, width of the level input; the value SHALL satisfy 2**LW > MAXP.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block accepts the operand beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 level  input  LW  number of approximated low bits p, sampled with the beat.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 y  output  WIDTH+1  approximate sum.
REQ-014 err  output  WIDTH+1  |exact sum - y| for the same beat.
REQ-015 clear_stats  input  1  synchronous clear of the statistics registers.
REQ-016 err_cnt  output  16  count of delivered beats with err != 0, saturating.
REQ-017 max_err  output  WIDTH+1  largest err delivered since reset or clear.

Function
REQ-018 Effective p SHALL be min(level, MAXP), using the level value captured with the beat.
REQ-019 Bits i<p: y[i] = a[i] | b[i].
REQ-020 Carry into bit p: a[p-1] & b[p-1] when p>0, and 0 when p=0.
REQ-021 Bits p..WIDTH-1: exact ripple/lookahead addition with that carry; y[WIDTH] = carry out of bit WIDTH-1.
REQ-022 p=0 SHALL produce the exact sum with err=0.
REQ-023 The exact sum SHALL be the full WIDTH+1-bit a+b; err SHALL be its unsigned absolute difference from y.
REQ-024 Pipeline stage S1 SHALL register a, b and effective p on the handshake in_valid & in_ready.
REQ-025 Stage S2 SHALL compute y and err from S1 and register them together with out_valid.
REQ-026 Latency SHALL be 2 cycles from input handshake to out_valid when out_ready is held high.
REQ-027 Throughput SHALL be 1 beat per cycle when out_ready is high.
REQ-028 S2 SHALL advance when !out_valid or out_ready.
REQ-029 S1 SHALL advance when its content moves to S2 or S1 is empty.
REQ-030 in_ready = !s1_valid or S2 advances; it SHALL NOT depend combinationally on in_valid.
REQ-031 While out_valid & !out_ready, y, err and out_valid SHALL hold stable; no beat SHALL be lost or duplicated.
REQ-032 On each output handshake, err_cnt SHALL increment if err != 0, saturating at 0xFFFF; max_err SHALL take max(max_err, err).
REQ-033 clear_stats SHALL zero err_cnt and max_err on the next edge, taking priority over a simultaneous update (the coinciding beat is not counted).
REQ-034 Beats SHALL be delivered in acceptance order.

Reset
REQ-035 rst_n low SHALL immediately clear s1_valid, out_valid, y, err, err_cnt and max_err to 0, independent of clk.
REQ-036 While rst_n is low, in_ready SHALL be 0; in_ready SHALL assert in the first cycle after reset release.
REQ-037 Beats in flight when reset asserts SHALL be discarded, and no out_valid SHALL follow for them.

Verification
REQ-038 WIDTH=8, MAXP=4, level=3, a=0x0F, b=0x01 -> y=0x00F, err=1, out_valid 2 cycles after accept, err_cnt=1.
REQ-039 level=0, a=0xFF, b=0x01 -> y=0x100, err=0, err_cnt unchanged; level=2, a=0x03, b=0x03 -> y=0x007, err=1.
REQ-040 level=7 (clamped to 4), a=0x0F, b=0x0F -> identical to level=4: y=0x01F, err=1, max_err=1.
REQ-041 Stream 4 back-to-back beats with out_ready low for 3 cycles -> in_ready drops after 2 accepted beats, outputs held stable, all 4 beats delivered in order after release.
REQ-042 Stats stress: force 65540 erroneous beats -> err_cnt=0xFFFF; clear_stats coinciding with an erroneous handshake -> err_cnt=0, max_err=0.
REQ-043 Assert rst_n low with 2 beats in flight -> out_valid=0 immediately, and no result appears after release until a new beat is accepted.
